// File: rtl/key_edge_timer.sv
// key_edge_timer
//
// Multi-channel debounced edge detector and interval timer for Morse key and
// button inputs. Each channel synchronises its raw input and debounces it. It
// emits one-cycle rise, fall and changed pulses. On every debounced change it
// also reports how long the previous stable level lasted.
//
// Parameters:
//   CHANNELS        number of independent channels (>=1)
//   SYNC_STAGES     synchroniser depth per channel (>=2)
//   DEBOUNCE_CYCLES consecutive disagreeing cycles needed to flip the level (>=1)
//   DUR_WIDTH       width of each interval counter (>=2)
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   din        raw asynchronous inputs, one bit per channel
//   level      debounced level per channel
//   rise       one-cycle pulse when level goes 0->1
//   fall       one-cycle pulse when level goes 1->0
//   ischanged  rise | fall
//   dur_valid  one-cycle pulse; dur/dur_lvl/dur_sat of that channel are fresh
//   dur        previous interval length, channel i at [i*DUR_WIDTH +: DUR_WIDTH]
//   dur_lvl    level that the reported interval had
//   dur_sat    reported interval hit the counter limit
module key_edge_timer #(
  parameter int CHANNELS        = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 8,
  parameter int DUR_WIDTH       = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [CHANNELS-1:0]           din,
  output logic [CHANNELS-1:0]           level,
  output logic [CHANNELS-1:0]           rise,
  output logic [CHANNELS-1:0]           fall,
  output logic [CHANNELS-1:0]           ischanged,
  output logic [CHANNELS-1:0]           dur_valid,
  output logic [CHANNELS*DUR_WIDTH-1:0] dur,
  output logic [CHANNELS-1:0]           dur_lvl,
  output logic [CHANNELS-1:0]           dur_sat
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DUR_WIDTH-1:0] RUN_MAX  = '1;

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
      logic [SYNC_STAGES-1:0] sync_reg;
      logic [CNT_W-1:0]       cnt_reg;
      logic [DUR_WIDTH-1:0]   run_reg;
      logic [DUR_WIDTH-1:0]   dur_reg;
      logic                   level_reg;
      logic                   rise_reg;
      logic                   fall_reg;
      logic                   changed_reg;
      logic                   dur_valid_reg;
      logic                   dur_lvl_reg;
      logic                   dur_sat_reg;
      logic                   s;
      logic                   change;

      assign s = sync_reg[SYNC_STAGES-1];
      // The level flips on the edge where the input has disagreed for the
      // last of DEBOUNCE_CYCLES consecutive cycles.
      assign change = (s != level_reg) && (cnt_reg == CNT_LAST);

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          sync_reg <= '0;
        end else begin
          sync_reg <= {sync_reg[SYNC_STAGES-2:0], din[gi]};
        end
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          cnt_reg       <= '0;
          run_reg       <= '0;
          dur_reg       <= '0;
          level_reg     <= 1'b0;
          rise_reg      <= 1'b0;
          fall_reg      <= 1'b0;
          changed_reg   <= 1'b0;
          dur_valid_reg <= 1'b0;
          dur_lvl_reg   <= 1'b0;
          dur_sat_reg   <= 1'b0;
        end else begin
          rise_reg      <= 1'b0;
          fall_reg      <= 1'b0;
          changed_reg   <= 1'b0;
          dur_valid_reg <= 1'b0;

          // One cycle of agreement restarts the count, so short glitches
          // never reach the level.
          if (s == level_reg || cnt_reg == CNT_LAST) begin
            cnt_reg <= '0;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end

          if (change) begin
            level_reg     <= s;
            rise_reg      <= s;
            fall_reg      <= ~s;
            changed_reg   <= 1'b1;
            dur_valid_reg <= 1'b1;
            dur_reg       <= run_reg;
            dur_lvl_reg   <= level_reg;
            dur_sat_reg   <= (run_reg == RUN_MAX);
            // The change edge itself is the first cycle of the new interval.
            run_reg       <= DUR_WIDTH'(1);
          end else if (run_reg != RUN_MAX) begin
            run_reg <= run_reg + DUR_WIDTH'(1);
          end
        end
      end

      assign level[gi]                          = level_reg;
      assign rise[gi]                           = rise_reg;
      assign fall[gi]                           = fall_reg;
      assign ischanged[gi]                      = changed_reg;
      assign dur_valid[gi]                      = dur_valid_reg;
      assign dur[gi*DUR_WIDTH +: DUR_WIDTH]     = dur_reg;
      assign dur_lvl[gi]                        = dur_lvl_reg;
      assign dur_sat[gi]                        = dur_sat_reg;
    end
  endgenerate

endmodule

// File: tb/tb_key_edge_timer.sv
// Directed bench for key_edge_timer with CHANNELS=2, SYNC_STAGES=2,
// DEBOUNCE_CYCLES=4, DUR_WIDTH=8. Inputs are driven and outputs sampled on the
// falling clock edge. "Edge m" counts rising edges after the falling edge on
// which the stimulus was applied.
module tb_key_edge_timer;
  localparam int CH  = 2;
  localparam int DW  = 8;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [CH-1:0]   din = '0;
  logic [CH-1:0]   level, rise, fall, ischanged, dur_valid, dur_lvl, dur_sat;
  logic [CH*DW-1:0] dur;

  int n_cmp = 0;
  int n_err = 0;

  key_edge_timer #(
    .CHANNELS(CH), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .DUR_WIDTH(DW)
  ) dut (
    .clk(clk), .reset(reset), .din(din), .level(level), .rise(rise),
    .fall(fall), .ischanged(ischanged), .dur_valid(dur_valid), .dur(dur),
    .dur_lvl(dur_lvl), .dur_sat(dur_sat)
  );

  always #5 clk = ~clk;

  task automatic test_reset;
    reset = 1'b1;
    din   = 2'b11;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({level, rise, fall, ischanged, dur_valid, dur, dur_lvl, dur_sat} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs got level=%b rise=%b fall=%b chg=%b dv=%b dur=%h lvl=%b sat=%b want all 0",
               level, rise, fall, ischanged, dur_valid, dur, dur_lvl, dur_sat);
    end
    reset = 1'b0;
    for (int m = 1; m <= 8; m++) begin
      @(negedge clk);
      n_cmp++;
      if (level !== ((m >= 6) ? 2'b11 : 2'b00) || rise !== ((m == 6) ? 2'b11 : 2'b00) ||
          ischanged !== ((m == 6) ? 2'b11 : 2'b00) || dur_valid !== ((m == 6) ? 2'b11 : 2'b00) ||
          fall !== 2'b00) begin
        n_err++;
        $display("FAIL release_edge%0d got level=%b rise=%b fall=%b chg=%b dv=%b", m,
                 level, rise, fall, ischanged, dur_valid);
      end
      if (m >= 6) begin
        n_cmp++;
        if (dur !== 16'h0505 || dur_lvl !== 2'b00 || dur_sat !== 2'b00) begin
          n_err++;
          $display("FAIL first_report edge%0d got dur=%h lvl=%b sat=%b want 0505/00/00", m,
                   dur, dur_lvl, dur_sat);
        end
      end
    end
    $display("reset/release: first report dur=%h", dur);
    din = 2'b00;
    repeat (20) @(negedge clk);
    n_cmp++;
    if (level !== 2'b00) begin
      n_err++;
      $display("FAIL reset_return_low got %b want 00", level);
    end
  endtask

  task automatic test_glitch;
    din[0] = 1'b1;
    for (int m = 1; m <= 15; m++) begin
      @(negedge clk);
      n_cmp++;
      if (level[0] !== 1'b0 || rise[0] !== 1'b0 || fall[0] !== 1'b0 || dur_valid[0] !== 1'b0) begin
        n_err++;
        $display("FAIL glitch_edge%0d got level=%b rise=%b fall=%b dv=%b want 0", m,
                 level[0], rise[0], fall[0], dur_valid[0]);
      end
      if (m == 3) din[0] = 1'b0;
    end
    $display("glitch: 3-cycle pulse filtered");
  endtask

  task automatic test_pulse;
    din[0] = 1'b1;
    for (int m = 1; m <= 30; m++) begin
      @(negedge clk);
      n_cmp++;
      if (level[0] !== (m >= 6 && m < 26) || rise[0] !== (m == 6) || fall[0] !== (m == 26) ||
          ischanged[0] !== (m == 6 || m == 26) || dur_valid[0] !== (m == 6 || m == 26)) begin
        n_err++;
        $display("FAIL pulse_edge%0d got level=%b rise=%b fall=%b chg=%b dv=%b", m,
                 level[0], rise[0], fall[0], ischanged[0], dur_valid[0]);
      end
      n_cmp++;
      if (level[1] !== 1'b0 || rise[1] !== 1'b0 || fall[1] !== 1'b0 || dur_valid[1] !== 1'b0) begin
        n_err++;
        $display("FAIL pulse_ch1_quiet edge%0d got level=%b rise=%b fall=%b dv=%b", m,
                 level[1], rise[1], fall[1], dur_valid[1]);
      end
      if (m == 26) begin
        n_cmp++;
        if (dur[7:0] !== 8'd20 || dur_lvl[0] !== 1'b1 || dur_sat[0] !== 1'b0) begin
          n_err++;
          $display("FAIL pulse_report got dur=%0d lvl=%b sat=%b want 20/1/0",
                   dur[7:0], dur_lvl[0], dur_sat[0]);
        end
        $display("pulse: fall report dur=%0d lvl=%b sat=%b", dur[7:0], dur_lvl[0], dur_sat[0]);
      end
      if (m == 20) din[0] = 1'b0;
    end
  endtask

  task automatic test_saturation;
    din[0] = 1'b1;
    for (int m = 1; m <= 310; m++) begin
      @(negedge clk);
      n_cmp++;
      if (level[0] !== (m >= 6 && m < 306)) begin
        n_err++;
        $display("FAIL sat_level edge%0d got %b", m, level[0]);
      end
      if (m == 306) begin
        n_cmp++;
        if (fall[0] !== 1'b1 || dur_valid[0] !== 1'b1 || dur[7:0] !== 8'd255 ||
            dur_sat[0] !== 1'b1 || dur_lvl[0] !== 1'b1) begin
          n_err++;
          $display("FAIL sat_report got fall=%b dv=%b dur=%0d sat=%b lvl=%b want 1/1/255/1/1",
                   fall[0], dur_valid[0], dur[7:0], dur_sat[0], dur_lvl[0]);
        end
        $display("saturation: fall report dur=%0d sat=%b", dur[7:0], dur_sat[0]);
      end
      if (m == 300) din[0] = 1'b0;
    end
  endtask

  task automatic test_reset_mid;
    din = 2'b10;
    repeat (4) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    n_cmp++;
    if ({level, rise, fall, ischanged, dur_valid, dur, dur_lvl, dur_sat} !== '0) begin
      n_err++;
      $display("FAIL midreset_immediate got level=%b dv=%b dur=%h lvl=%b sat=%b want all 0",
               level, dur_valid, dur, dur_lvl, dur_sat);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int m = 1; m <= 10; m++) begin
      @(negedge clk);
      n_cmp++;
      if (level !== ((m >= 6) ? 2'b10 : 2'b00) || rise !== ((m == 6) ? 2'b10 : 2'b00) ||
          dur_valid !== ((m == 6) ? 2'b10 : 2'b00) || fall !== 2'b00 ||
          ischanged !== ((m == 6) ? 2'b10 : 2'b00)) begin
        n_err++;
        $display("FAIL midreset_edge%0d got level=%b rise=%b fall=%b chg=%b dv=%b", m,
                 level, rise, fall, ischanged, dur_valid);
      end
      if (m == 6) begin
        n_cmp++;
        if (dur[15:8] !== 8'd5 || dur_lvl[1] !== 1'b0 || dur_sat[1] !== 1'b0) begin
          n_err++;
          $display("FAIL midreset_report got dur=%0d lvl=%b sat=%b want 5/0/0",
                   dur[15:8], dur_lvl[1], dur_sat[1]);
        end
        $display("mid-debounce reset: ch1 report dur=%0d", dur[15:8]);
      end
    end
  endtask

  // Expected behaviour for inputs whose segments all last >= 4 cycles:
  // level is the input delayed by 6 cycles, and each report gives the
  // distance between successive level changes.
  task automatic test_crosstalk;
    int t0[6];
    int t1[6];
    logic [1:0]  din_at[0:99];
    logic [1:0]  lvl_e, prev_e, rise_e, fall_e, chg_e, dlvl_e, dsat_e;
    logic [15:0] dur_e;
    int last[2];
    int len;
    t0 = '{3, 12, 20, 31, 36, 50};
    t1 = '{7, 11, 25, 29, 45, 60};
    for (int k = 0; k < 100; k++) begin
      logic [1:0] v;
      v = 2'b00;
      for (int j = 0; j < 6; j++) begin
        if (k >= t0[j]) v[0] = ~v[0];
        if (k >= t1[j]) v[1] = ~v[1];
      end
      din_at[k] = v;
    end
    reset = 1'b1;
    din = 2'b00;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    din = din_at[0];
    prev_e = 2'b00; dur_e = '0; dlvl_e = 2'b00; dsat_e = 2'b00;
    last[0] = 1; last[1] = 1;
    for (int m = 1; m <= 90; m++) begin
      @(negedge clk);
      for (int c = 0; c < 2; c++) begin
        lvl_e[c] = (m >= 6) ? din_at[m-6][c] : 1'b0;
        if (lvl_e[c] != prev_e[c]) begin
          len = m - last[c];
          dur_e[c*8 +: 8] = (len >= 255) ? 8'hFF : 8'(len);
          dsat_e[c] = (len >= 255);
          dlvl_e[c] = prev_e[c];
          last[c] = m;
        end
      end
      rise_e = lvl_e & ~prev_e;
      fall_e = ~lvl_e & prev_e;
      chg_e  = rise_e | fall_e;
      n_cmp++;
      if (level !== lvl_e || rise !== rise_e || fall !== fall_e ||
          ischanged !== chg_e || dur_valid !== chg_e) begin
        n_err++;
        $display("FAIL xtalk_pulses edge%0d got level=%b rise=%b fall=%b chg=%b dv=%b want %b/%b/%b/%b/%b",
                 m, level, rise, fall, ischanged, dur_valid, lvl_e, rise_e, fall_e, chg_e, chg_e);
      end
      n_cmp++;
      if (dur !== dur_e || dur_lvl !== dlvl_e || dur_sat !== dsat_e) begin
        n_err++;
        $display("FAIL xtalk_report edge%0d got dur=%h lvl=%b sat=%b want %h/%b/%b",
                 m, dur, dur_lvl, dur_sat, dur_e, dlvl_e, dsat_e);
      end
      if (chg_e != 2'b00)
        $display("xtalk edge%0d: dv=%b dur=%h dur_lvl=%b", m, dur_valid, dur, dur_lvl);
      prev_e = lvl_e;
      din = din_at[m];
    end
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_pulse();
    test_saturation();
    test_reset_mid();
    test_crosstalk();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
